// File: rtl/seg_ctrl_pkg.sv
// seg_ctrl_pkg
//   Shared definitions for the seven-segment compare controller: register
//   offsets (wbs_adr_i[3:2]), CTRL and STATUS bit positions, the update
//   sequencer state encoding, update source ids and the buffered WB write
//   request struct.
package seg_ctrl_pkg;

  // Register offsets, word index taken from wbs_adr_i[3:2]
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // CTRL bits
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_LA_EN_BIT = 1;
  localparam logic [1:0] CTRL_RESET = 2'b01;

  // STATUS bits
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_WB_PEND_BIT = 1;
  localparam int STAT_LA_PEND_BIT = 2;
  localparam int STAT_COUNT_LSB   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } seq_state_e;

  // Arbiter request/grant vectors are indexed by these ids
  typedef enum logic {
    SRC_WB = 1'b0,
    SRC_LA = 1'b1
  } src_e;

  // WB write captured on the ack edge, committed one cycle later
  typedef struct packed {
    logic        en;
    logic [1:0]  adr;
    logic [23:0] dat;
    logic [3:0]  sel;
  } wb_wr_t;

endpackage

// File: rtl/seg_update_arb.sv
// seg_update_arb
//   Two-way round-robin arbiter for compare updates. A lone request is
//   granted directly; when both sources request, the one that did not win
//   last time is granted. Purely combinational; the caller decides when a
//   grant is allowed to take effect.
// Ports
//   i_req        [1:0] requests, index SRC_WB / SRC_LA
//   i_last_grant       source granted most recently
//   o_grant      [1:0] one-hot grant (or zero when no request)
module seg_update_arb
  import seg_ctrl_pkg::*;
(
  input  logic [1:0] i_req,
  input  src_e       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (&i_req) begin
      o_grant = (i_last_grant == SRC_LA) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/seg_compare_ctrl.sv
// seg_compare_ctrl
//   Wishbone-programmable controller for the seven-segment seconds counter's
//   compare port. Holds the 24-bit compare value, collects update requests
//   from WB writes and from a logic-analyzer request line, arbitrates them
//   round-robin, and applies each granted value through a setup / one-cycle
//   update pulse / hold sequence.
// Ports
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i/dat_i/adr_i, wbs_ack_o, wbs_dat_o
//                                WB slave, 4 word registers at BASE_ADDR
//   la_req_i, la_compare_i       LA request (rising edge) and its value
//   la_grant_o                   one-cycle pulse when an LA request is granted
//   compare_o, update_compare_o  to seven_segment_seconds
//   busy_o                       update sequence in progress
module seg_compare_ctrl
  import seg_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter logic [23:0] RESET_COMPARE = 24'h000100,
  parameter int          HOLD_CYCLES   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        la_req_i,
  input  logic [23:0] la_compare_i,
  output logic        la_grant_o,
  output logic [23:0] compare_o,
  output logic        update_compare_o,
  output logic        busy_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  // ---------------------------------------------------------------- state
  logic              r_ack;
  logic [31:0]       r_dat;
  wb_wr_t            r_wr;
  logic [1:0]        r_ctrl;
  logic [23:0]       r_wb_shadow;
  logic [23:0]       r_la_shadow;
  logic              r_wb_pend;
  logic              r_la_pend;
  logic              r_la_req_d;
  logic              r_la_grant;
  src_e              r_last_grant;
  logic [23:0]       r_compare;
  logic [7:0]        r_count;
  logic [HW-1:0]     r_hold_cnt;
  seq_state_e        r_state;

  // ---------------------------------------------------------------- wires
  logic              w_dec;
  logic              w_req;
  logic [31:0]       w_rdata;
  logic              w_busy;
  logic              w_wr_cmp;
  logic              w_wb_set;
  logic              w_la_set;
  logic [1:0]        w_arb_grant;
  logic [1:0]        w_grant;
  seq_state_e        w_next;
  logic              w_unused;

  // Address bits below the word index, the top data byte and sel[3] carry
  // nothing for these registers.
  assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};

  assign w_dec  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // !r_ack keeps a master that holds stb through the ack cycle from
  // getting a second ack for the same transfer.
  assign w_req  = wbs_stb_i & wbs_cyc_i & w_dec & ~r_ack;
  assign w_busy = (r_state != S_IDLE);

  // ------------------------------------------------------------ WB slave
  always_comb begin
    w_rdata = '0;
    case (wbs_adr_i[3:2])
      REG_CTRL:    w_rdata[1:0]  = r_ctrl;
      REG_COMPARE: w_rdata[23:0] = r_compare;
      REG_STATUS: begin
        w_rdata[STAT_BUSY_BIT]          = w_busy;
        w_rdata[STAT_WB_PEND_BIT]       = r_wb_pend;
        w_rdata[STAT_LA_PEND_BIT]       = r_la_pend;
        w_rdata[STAT_COUNT_LSB +: 8]    = r_count;
      end
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_wr  <= '0;
    end else begin
      r_ack     <= w_req;
      r_dat     <= (w_req && !wbs_we_i) ? w_rdata : 32'h0;
      r_wr.en   <= w_req & wbs_we_i;
      r_wr.adr  <= wbs_adr_i[3:2];
      r_wr.dat  <= wbs_dat_i[23:0];
      r_wr.sel  <= wbs_sel_i;
    end
  end

  // The write is committed the cycle after ack, so the pending flag shows
  // up at ack+1.
  assign w_wr_cmp = r_wr.en && (r_wr.adr == REG_COMPARE);
  assign w_wb_set = w_wr_cmp && (|r_wr.sel[2:0]);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ctrl      <= CTRL_RESET;
      r_wb_shadow <= RESET_COMPARE;
    end else begin
      if (r_wr.en && (r_wr.adr == REG_CTRL) && r_wr.sel[0]) begin
        r_ctrl <= r_wr.dat[1:0];
      end
      if (w_wr_cmp) begin
        for (int b = 0; b < 3; b++) begin
          if (r_wr.sel[b]) r_wb_shadow[8*b +: 8] <= r_wr.dat[8*b +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------ LA capture
  assign w_la_set = la_req_i & ~r_la_req_d & r_ctrl[CTRL_LA_EN_BIT];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_la_req_d  <= 1'b0;
      r_la_shadow <= RESET_COMPARE;
    end else begin
      r_la_req_d <= la_req_i;
      if (w_la_set) r_la_shadow <= la_compare_i;
    end
  end

  // ------------------------------------------------------------ arbitration
  seg_update_arb u_arb (
    .i_req        ({r_la_pend, r_wb_pend}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant)
  );

  // Grants only take effect from IDLE with the controller enabled; with
  // enable low everything pending simply waits.
  assign w_grant = (r_state == S_IDLE && r_ctrl[CTRL_EN_BIT]) ? w_arb_grant : 2'b00;

  // A new request in the same cycle as its grant re-arms the pending flag
  // (the shadow already holds the newer value).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wb_pend    <= 1'b0;
      r_la_pend    <= 1'b0;
      r_la_grant   <= 1'b0;
      r_last_grant <= SRC_LA;
    end else begin
      r_wb_pend  <= w_wb_set | (r_wb_pend & ~w_grant[SRC_WB]);
      r_la_pend  <= w_la_set | (r_la_pend & ~w_grant[SRC_LA]);
      r_la_grant <= w_grant[SRC_LA];
      if (w_grant[SRC_WB])      r_last_grant <= SRC_WB;
      else if (w_grant[SRC_LA]) r_last_grant <= SRC_LA;
    end
  end

  // ------------------------------------------------------------ sequencer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|w_grant) w_next = S_SETUP;
      S_SETUP: w_next = S_PULSE;
      S_PULSE: w_next = S_HOLD;
      S_HOLD:  if (r_hold_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // The granted shadow is loaded straight into compare_o on the grant edge,
  // which is the SETUP entry; compare_o is therefore stable through
  // SETUP, PULSE and HOLD.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_compare  <= RESET_COMPARE;
      r_count    <= 8'd0;
      r_hold_cnt <= '0;
    end else begin
      if (w_grant[SRC_WB])      r_compare <= r_wb_shadow;
      else if (w_grant[SRC_LA]) r_compare <= r_la_shadow;

      if (r_state == S_PULSE) begin
        r_count    <= r_count + 8'd1;
        r_hold_cnt <= HW'(HOLD_CYCLES - 1);
      end else if (r_state == S_HOLD && r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign wbs_ack_o        = r_ack;
  assign wbs_dat_o        = r_dat;
  assign la_grant_o       = r_la_grant;
  assign compare_o        = r_compare;
  // Decoded from the state register so it drops with reset asynchronously.
  assign update_compare_o = (r_state == S_PULSE);
  assign busy_o           = w_busy;

endmodule

// File: tb/tb_seg_compare_ctrl.sv
module tb_seg_compare_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_CMP  = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_RSVD = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = 32'h0, wbs_adr_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_req_i = 1'b0;
  logic [23:0] la_compare_i = 24'h0;
  logic        la_grant_o, update_compare_o, busy_o;
  logic [23:0] compare_o;

  seg_compare_ctrl #(.BASE_ADDR(BASE), .RESET_COMPARE(24'h000100), .HOLD_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req_i), .la_compare_i(la_compare_i), .la_grant_o(la_grant_o),
    .compare_o(compare_o), .update_compare_o(update_compare_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Passive monitor: cycle counter, update pulses (cycle, value, width) and LA grants
  int          cyc = 0;
  int          pulse_cnt = 0, grant_cnt = 0, width_err = 0, pulse_cyc = -1;
  logic        prev_upd = 1'b0;
  logic [23:0] pulse_vals[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (update_compare_o) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_cyc <= cyc;
      pulse_vals.push_back(compare_o);
      if (prev_upd) width_err <= width_err + 1;
    end
    if (la_grant_o) grant_cnt <= grant_cnt + 1;
    prev_upd <= update_compare_o;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 600000", $time);
    $fatal(1);
  end

  // ------------------------------------------------------------ bus helpers
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; la_req_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          output int t_req, output int t_ack, output bit ok);
    @(negedge clk);
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    wbs_we_i = 1; wbs_stb_i = 1; wbs_cyc_i = 1;
    t_req = cyc; t_ack = -1; ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin ok = 1; t_ack = cyc; end
    end
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat, output bit ok);
    @(negedge clk);
    wbs_adr_i = adr; wbs_sel_i = 4'hF; wbs_we_i = 0; wbs_stb_i = 1; wbs_cyc_i = 1;
    ok = 0; dat = 32'hDEAD_BEEF;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin ok = 1; dat = wbs_dat_o; end
    end
    wbs_stb_i = 0; wbs_cyc_i = 0;
  endtask

  task automatic la_pulse(input logic [23:0] v);
    @(negedge clk);
    la_compare_i = v; la_req_i = 1;
    @(negedge clk);
    la_req_i = 0; la_compare_i = 24'($urandom);
  endtask

  // WB write of wv whose commit cycle coincides with an LA edge carrying lv
  task automatic tie_req(input logic [23:0] wv, input logic [23:0] lv);
    bit ok;
    @(negedge clk);
    wbs_adr_i = A_CMP; wbs_dat_i = {8'h0, wv}; wbs_sel_i = 4'hF;
    wbs_we_i = 1; wbs_stb_i = 1; wbs_cyc_i = 1;
    ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (wbs_ack_o) ok = 1;
    end
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    la_compare_i = lv; la_req_i = 1;
    @(negedge clk);
    la_req_i = 0;
  endtask

  // Idle means busy low for several consecutive cycles (a pending request
  // would have been granted within that window).
  task automatic wait_idle(output bit ok);
    int quiet = 0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      quiet = busy_o ? 0 : quiet + 1;
      if (quiet >= 4) ok = 1;
    end
    #1;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    logic [31:0] d; bit ok;
    do_reset();
    #1;
    chk_cnt++; if (compare_o !== 24'h000100) $display("FAIL reset_compare: got %h want 000100", compare_o); else pass_cnt++;
    chk_cnt++; if (update_compare_o !== 1'b0 || busy_o !== 1'b0 || la_grant_o !== 1'b0)
      $display("FAIL reset_outputs: got upd=%b busy=%b grant=%b want 0 0 0", update_compare_o, busy_o, la_grant_o); else pass_cnt++;
    chk_cnt++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) $display("FAIL reset_wb: got ack=%b dat=%h want 0 0", wbs_ack_o, wbs_dat_o); else pass_cnt++;
    wb_read(A_STAT, d, ok);
    chk_cnt++; if (!ok || d !== 32'h0) $display("FAIL reset_status: got ack=%b %h want 1 00000000", ok, d); else pass_cnt++;
    wb_read(A_CTRL, d, ok);
    chk_cnt++; if (!ok || d !== 32'h1) $display("FAIL reset_ctrl: got ack=%b %h want 1 00000001", ok, d); else pass_cnt++;
  endtask

  task automatic test_regs();
    logic [31:0] d; bit ok; int tr, ta, p0;
    p0 = pulse_cnt;
    wb_write(A_RSVD, 32'hFFFF_FFFF, 4'hF, tr, ta, ok);
    chk_cnt++; if (!ok) $display("FAIL rsvd_write_ack: got no ack want ack"); else pass_cnt++;
    wb_read(A_RSVD, d, ok);
    chk_cnt++; if (!ok || d !== 32'h0) $display("FAIL rsvd_read: got ack=%b %h want 1 00000000", ok, d); else pass_cnt++;
    wb_write(BASE + 32'h10, 32'h55, 4'hF, tr, ta, ok);
    chk_cnt++; if (ok) $display("FAIL undecoded_ack: got ack want none"); else pass_cnt++;
    wb_write(A_CTRL, 32'h0, 4'h0, tr, ta, ok);
    wb_read(A_CTRL, d, ok);
    chk_cnt++; if (d !== 32'h1) $display("FAIL ctrl_sel_gate: got %h want 00000001", d); else pass_cnt++;
    wb_write(A_STAT, 32'hFFFF_FFFF, 4'hF, tr, ta, ok);
    wb_read(A_STAT, d, ok);
    chk_cnt++; if (d !== 32'h0 || pulse_cnt != p0) $display("FAIL status_ro: got %h pulses=%0d want 00000000 %0d", d, pulse_cnt, p0); else pass_cnt++;
  endtask

  task automatic test_write();
    logic [31:0] d; bit ok; int tr, ta, p0;
    do_reset();
    p0 = pulse_cnt;
    wb_write(A_CMP, 32'h0000_ABCD, 4'hF, tr, ta, ok);
    chk_cnt++; if (!ok || ta != tr + 1) $display("FAIL ack_latency: got ack=%b at +%0d want +1", ok, ta - tr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (wbs_ack_o !== 1'b0) $display("FAIL ack_width: got ack=%b one cycle later want 0", wbs_ack_o); else pass_cnt++;
    wait_idle(ok);
    chk_cnt++; if (!ok) $display("FAIL write_idle_timeout: got busy want idle"); else pass_cnt++;
    chk_cnt++; if (pulse_cnt != p0 + 1 || pulse_cyc != ta + 3)
      $display("FAIL write_pulse: got %0d pulses at ack+%0d want 1 at ack+3", pulse_cnt - p0, pulse_cyc - ta); else pass_cnt++;
    chk_cnt++; if (compare_o !== 24'h00ABCD) $display("FAIL write_compare: got %h want 00abcd", compare_o); else pass_cnt++;
    wb_read(A_STAT, d, ok);
    chk_cnt++; if (d !== 32'h0000_0100) $display("FAIL write_count: got %h want 00000100", d); else pass_cnt++;
    // byte merge: only byte 1 written
    wb_write(A_CMP, 32'hFFFF_EE77, 4'b0010, tr, ta, ok);
    wait_idle(ok);
    wb_read(A_CMP, d, ok);
    chk_cnt++; if (d !== 32'h0000_EECD) $display("FAIL byte_merge: got %h want 0000eecd", d); else pass_cnt++;
    chk_cnt++; if (width_err != 0) $display("FAIL pulse_width: got %0d wide pulses want 0", width_err); else pass_cnt++;
  endtask

  task automatic test_tie();
    bit ok; int tr, ta, p0, g0;
    do_reset();
    wb_write(A_CTRL, 32'h3, 4'h1, tr, ta, ok);
    p0 = pulse_vals.size(); g0 = grant_cnt;
    tie_req(24'h000200, 24'h000300);
    wait_idle(ok);
    chk_cnt++; if (pulse_vals.size() != p0 + 2) $display("FAIL tie_pulses: got %0d want 2", pulse_vals.size() - p0);
    else if (pulse_vals[p0] !== 24'h000200 || pulse_vals[p0+1] !== 24'h000300)
      $display("FAIL tie_order: got %h,%h want 000200,000300", pulse_vals[p0], pulse_vals[p0+1]);
    else pass_cnt++;
    chk_cnt++; if (grant_cnt != g0 + 1) $display("FAIL tie_la_grant: got %0d want 1", grant_cnt - g0); else pass_cnt++;
    chk_cnt++; if (compare_o !== 24'h000300) $display("FAIL tie_final: got %h want 000300", compare_o); else pass_cnt++;
    // last winner was LA; a WB-only update makes WB the last winner, so the
    // next tie must go to LA first.
    wb_write(A_CMP, 32'h400, 4'hF, tr, ta, ok);
    wait_idle(ok);
    p0 = pulse_vals.size();
    tie_req(24'h000500, 24'h000600);
    wait_idle(ok);
    chk_cnt++; if (pulse_vals.size() != p0 + 2) $display("FAIL rr_pulses: got %0d want 2", pulse_vals.size() - p0);
    else if (pulse_vals[p0] !== 24'h000600 || pulse_vals[p0+1] !== 24'h000500)
      $display("FAIL rr_order: got %h,%h want 000600,000500", pulse_vals[p0], pulse_vals[p0+1]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; bit ok; int tr, ta, p0;
    do_reset();
    p0 = pulse_vals.size();
    wb_write(A_CMP, 32'h05, 4'hF, tr, ta, ok);
    wb_write(A_CMP, 32'h11, 4'hF, tr, ta, ok);
    chk_cnt++; if (busy_o !== 1'b1) $display("FAIL b2b_busy: got busy=%b during second write want 1", busy_o); else pass_cnt++;
    wb_write(A_CMP, 32'h22, 4'hF, tr, ta, ok);
    wait_idle(ok);
    chk_cnt++; if (pulse_vals.size() != p0 + 2) $display("FAIL b2b_pulses: got %0d want 2", pulse_vals.size() - p0);
    else if (pulse_vals[p0] !== 24'h05 || pulse_vals[p0+1] !== 24'h22)
      $display("FAIL b2b_values: got %h,%h want 000005,000022", pulse_vals[p0], pulse_vals[p0+1]);
    else pass_cnt++;
    wb_read(A_STAT, d, ok);
    chk_cnt++; if (d !== 32'h0000_0200) $display("FAIL b2b_status: got %h want 00000200", d); else pass_cnt++;
  endtask

  task automatic test_enable();
    logic [31:0] d; bit ok; int tr, ta, p0, g0;
    do_reset();
    wb_write(A_CTRL, 32'h0, 4'h1, tr, ta, ok);
    p0 = pulse_cnt;
    wb_write(A_CMP, 32'h77, 4'hF, tr, ta, ok);
    repeat (20) @(negedge clk);
    #1;
    chk_cnt++; if (pulse_cnt != p0 || compare_o !== 24'h000100)
      $display("FAIL disabled_no_pulse: got %0d pulses cmp=%h want 0 000100", pulse_cnt - p0, compare_o); else pass_cnt++;
    wb_read(A_STAT, d, ok);
    chk_cnt++; if (d[2:0] !== 3'b010) $display("FAIL disabled_pending: got %b want 010", d[2:0]); else pass_cnt++;
    wb_write(A_CTRL, 32'h1, 4'h1, tr, ta, ok);
    wait_idle(ok);
    chk_cnt++; if (pulse_cnt != p0 + 1 || compare_o !== 24'h77)
      $display("FAIL enable_apply: got %0d pulses cmp=%h want 1 000077", pulse_cnt - p0, compare_o); else pass_cnt++;
    // LA pending survives la_en being cleared
    wb_write(A_CTRL, 32'h2, 4'h1, tr, ta, ok);
    la_pulse(24'h000088);
    wb_read(A_STAT, d, ok);
    chk_cnt++; if (d[2:0] !== 3'b100) $display("FAIL la_pending: got %b want 100", d[2:0]); else pass_cnt++;
    g0 = grant_cnt;
    wb_write(A_CTRL, 32'h1, 4'h1, tr, ta, ok);
    wait_idle(ok);
    chk_cnt++; if (compare_o !== 24'h88 || grant_cnt != g0 + 1)
      $display("FAIL la_retained: got cmp=%h grants=%0d want 000088 1", compare_o, grant_cnt - g0); else pass_cnt++;
    p0 = pulse_cnt;
    la_pulse(24'h000099);
    wait_idle(ok);
    chk_cnt++; if (pulse_cnt != p0 || compare_o !== 24'h88)
      $display("FAIL la_disabled: got %0d pulses cmp=%h want 0 000088", pulse_cnt - p0, compare_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; bit ok, seen; int tr, ta;
    do_reset();
    wb_write(A_CMP, 32'h123, 4'hF, tr, ta, ok);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (update_compare_o) seen = 1;
    end
    chk_cnt++; if (!seen) $display("FAIL mid_pulse_seen: got no pulse want pulse"); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (update_compare_o !== 1'b0 || compare_o !== 24'h000100 || busy_o !== 1'b0)
      $display("FAIL mid_reset: got upd=%b cmp=%h busy=%b want 0 000100 0", update_compare_o, compare_o, busy_o); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(A_STAT, d, ok);
    chk_cnt++; if (d !== 32'h0) $display("FAIL mid_reset_status: got %h want 00000000", d); else pass_cnt++;
  endtask

  // Random WB/LA updates, one at a time; model = byte-merged WB shadow,
  // last applied value, and update count modulo 256.
  task automatic test_random_wrap();
    logic [31:0] d; bit ok; int tr, ta, errs, model_cnt;
    logic [23:0] wb_model, val, expv;
    logic [3:0]  sel;
    bit          have_shadow;
    do_reset();
    wb_write(A_CTRL, 32'h3, 4'h1, tr, ta, ok);
    errs = 0; model_cnt = 0; have_shadow = 0; wb_model = 24'h0;
    for (int i = 0; i < 256; i++) begin
      val = 24'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        la_pulse(val);
        expv = val;
      end else begin
        sel = have_shadow ? 4'($urandom_range(7, 1)) : 4'hF;
        for (int b = 0; b < 3; b++) if (sel[b]) wb_model[8*b +: 8] = val[8*b +: 8];
        have_shadow = 1;
        wb_write(A_CMP, {8'($urandom), val}, sel, tr, ta, ok);
        expv = wb_model;
      end
      wait_idle(ok);
      model_cnt = (model_cnt + 1) % 256;
      if (compare_o !== expv) begin
        errs++;
        if (errs < 4) $display("FAIL random_compare[%0d]: got %h want %h", i, compare_o, expv);
      end
      if (i == 254) begin
        wb_read(A_STAT, d, ok);
        chk_cnt++; if (d[15:8] !== 8'(model_cnt)) $display("FAIL count_255: got %0d want %0d", d[15:8], model_cnt); else pass_cnt++;
      end
    end
    chk_cnt++; if (errs != 0) $display("FAIL random_updates: got %0d bad values want 0", errs); else pass_cnt++;
    wb_read(A_STAT, d, ok);
    chk_cnt++; if (d[15:8] !== 8'(model_cnt)) $display("FAIL count_wrap: got %0d want %0d", d[15:8], model_cnt); else pass_cnt++;
    chk_cnt++; if (width_err != 0) $display("FAIL pulse_width_final: got %0d wide pulses want 0", width_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_write();
    test_tie();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_random_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
